regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised register file for the pipelined core, generalising the 16x32 two-read/one-write file. Reads are registered with one cycle of latency. A same-cycle write is forwarded to the reads. A configurable PC alias index returns pc_in+PC_OFFSET. A per-register scoreboard of pending writes drives a hazard/stall output to the decode stage.

Parameters:
DATA_W, 32, data width of registers and ports
ADDR_W, 4, register address width
NUM_REGS, 16, number of architectural indices (must satisfy NUM_REGS <= 2**ADDR_W); includes the PC alias index
PC_IDX, 15, index that reads as pc_in+PC_OFFSET; has no storage
PC_OFFSET, 8, constant added to pc_in on a PC-alias read (DATA_W-bit wraparound add)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
re  input  1  read request; ra1/ra2 are sampled when re=1 and hazard=0
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
we3  input  1  write enable
wa3  input  ADDR_W  write address
wd3  input  DATA_W  write data
pc_in  input  DATA_W  current PC value
sb_set  input  1  marks sb_addr as having a write in flight
sb_addr  input  ADDR_W  scoreboard address to mark
rd1  output  DATA_W  registered read data, port 1
rd2  output  DATA_W  registered read data, port 2
rd_valid  output  1  rd1/rd2 updated by a read accepted in the previous cycle
hazard  output  1  combinational: the current read request is blocked
busy  output  NUM_REGS  scoreboard bits (bit i = write pending to register i)

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - All stored registers cleared to 0.
  - busy=0, rd1=0, rd2=0, rd_valid=0.
  - hazard evaluates to 0 while busy=0.
  - Reset mid-operation discards any pending read or write.
- Storage: one entry per index 0..NUM_REGS-1, except PC_IDX, which has no storage.
- Write: on posedge, if we3=1, wa3<NUM_REGS and wa3!=PC_IDX, then rf[wa3]<=wd3 and busy[wa3]<=0.
  - Writes to PC_IDX or to out-of-range addresses are ignored and leave busy unchanged.
- Scoreboard set: on posedge, if sb_set=1, sb_addr<NUM_REGS and sb_addr!=PC_IDX, then busy[sb_addr]<=1.
  - If a write and sb_set target the same address in the same cycle, the set wins: busy stays 1.
- Read source for each port p (ra = ra1 or ra2), evaluated in this order:
  1. ra==PC_IDX: pc_in+PC_OFFSET.
  2. ra>=NUM_REGS: 0.
  3. we3=1 and wa3==ra: wd3 (write-first bypass).
  4. Otherwise: rf[ra].
- Hazard (combinational): hazard = re AND (blk(ra1) OR blk(ra2)), where blk(ra) = busy[ra] AND ra<NUM_REGS AND ra!=PC_IDX AND NOT(we3 AND wa3==ra).
  - A write completing in the same cycle clears the hazard for that address; its data is forwarded.
  - hazard uses busy before this edge's update, so an sb_set in the same cycle does not block a same-cycle read.
- Read capture: on posedge, if re=1 and hazard=0, then rd1/rd2 <= their read sources and rd_valid<=1. Otherwise rd1/rd2 hold their values and rd_valid<=0.
  - Latency is exactly 1 cycle from accept to rd_valid.
- ra1==ra2 is legal; both ports return the same value.
- No internal FSM beyond the scoreboard. rd_valid is a one-cycle pulse per accepted read; back-to-back accepts keep it high.

Test Plan:
- Reset: write 0xDEADBEEF to r3, then pulse rst_n low mid-cycle -> rd1/rd2/rd_valid/busy drop to 0 immediately; a subsequent read of r3 returns 0x00000000.
- Basic write/read: write r5=0x12345678 (cycle N); read ra1=5, ra2=0 at N+1 -> rd1=0x12345678, rd2=0x00000000, rd_valid=1 at N+2.
- Bypass: in the same cycle we3=1, wa3=7, wd3=0xA5A5A5A5, re=1, ra1=7 -> rd1=0xA5A5A5A5 next cycle; ra2=7 with an old value is never returned.
- PC alias: pc_in=0x00000100, ra1=15 -> rd1=0x00000108; also pc_in=0xFFFFFFFC -> rd1=0x00000004 (wrap); a write to r15 with 0x1 -> no effect.
- Scoreboard stall:
  - sb_set r2; next cycle re=1, ra2=2 -> hazard=1, rd_valid=0, rd2 holds.
  - Write r2=0x55 in a later cycle with re=1, ra2=2 -> hazard=0, rd2=0x55, busy[2]=0.
  - sb_set and we3 on r4 in the same cycle -> busy[4] stays 1.
- Parameter sweep: DATA_W=16, NUM_REGS=8, ADDR_W=4, PC_IDX=7 -> reads of ra=9 return 0; writes to 9 are ignored; PC reads are 16-bit wrapped.

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb: parametrised register file with registered reads, write-first
// bypass, a PC alias index and a per-register pending-write scoreboard.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   re_i, ra1_i, ra2_i       read request and the two read addresses
//   we3_i, wa3_i, wd3_i      write port
//   pc_in_i                  current PC; read at PC_IDX as pc_in_i + PC_OFFSET
//   sb_set_i, sb_addr_i      mark a register as having a write in flight
//   rd1_o, rd2_o             registered read data (one cycle after accept)
//   rd_valid_o               pulse: read data updated by last cycle's accept
//   hazard_o                 combinational: current read request is blocked
//   busy_o                   scoreboard, bit i = write pending to register i
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned PC_IDX    = 15,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   ra1_i,
    input  logic [ADDR_W-1:0]   ra2_i,
    input  logic                we3_i,
    input  logic [ADDR_W-1:0]   wa3_i,
    input  logic [DATA_W-1:0]   wd3_i,
    input  logic [DATA_W-1:0]   pc_in_i,
    input  logic                sb_set_i,
    input  logic [ADDR_W-1:0]   sb_addr_i,
    output logic [DATA_W-1:0]   rd1_o,
    output logic [DATA_W-1:0]   rd2_o,
    output logic                rd_valid_o,
    output logic                hazard_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int unsigned       AW1       = ADDR_W + 1;
    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NumRegsA  = AW1'(NUM_REGS);
    localparam logic [ADDR_W-1:0] PcIdxA    = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PcOffsetD = DATA_W'(PC_OFFSET);

    // True for addresses that have real storage (in range and not the PC alias).
    function automatic logic is_stored(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NumRegsA) && (a != PcIdxA);
    endfunction

    logic wr_en;
    logic sb_en;

    assign wr_en = we3_i && is_stored(wa3_i);
    assign sb_en = sb_set_i && is_stored(sb_addr_i);

    // -----------------------------------------------------------------------
    // Storage: one flop row per stored index; the PC alias reads as zero here
    // and is substituted in the read mux.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rf_val [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_rf
        if (i == PC_IDX) begin : g_pc
            assign rf_val[i] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] reg_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    reg_q <= '0;
                end else if (wr_en && (wa3_i == ADDR_W'(i))) begin
                    reg_q <= wd3_i;
                end
            end

            assign rf_val[i] = reg_q;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard: a completing write clears its bit, then sb_set sets; the
    // order makes a same-cycle set win over a same-cycle clear.
    // -----------------------------------------------------------------------
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wa3_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (sb_en && (sb_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    // -----------------------------------------------------------------------
    // Read source and block detection, per port.
    // -----------------------------------------------------------------------
    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] src;
    logic [1:0]             busy_hit;
    logic [1:0]             bypass;
    logic [1:0]             blk;

    assign ra[0] = ra1_i;
    assign ra[1] = ra2_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            src[p]      = '0;
            busy_hit[p] = 1'b0;
            bypass[p]   = we3_i && (wa3_i == ra[p]);

            for (int i = 0; i < NUM_REGS; i++) begin
                if (ra[p] == ADDR_W'(i)) begin
                    busy_hit[p] = busy_q[i];
                end
            end

            if (ra[p] == PcIdxA) begin
                src[p] = pc_in_i + PcOffsetD;
            end else if ({1'b0, ra[p]} >= NumRegsA) begin
                src[p] = '0;
            end else if (bypass[p]) begin
                src[p] = wd3_i;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ra[p] == ADDR_W'(i)) begin
                        src[p] = rf_val[i];
                    end
                end
            end

            // A write landing this cycle resolves the pending hazard; the
            // data reaches the read through the bypass above.
            blk[p] = busy_hit[p] && is_stored(ra[p]) && !bypass[p];
        end
    end

    // busy_q is the pre-edge value, so a same-cycle sb_set never blocks.
    assign hazard_o = re_i && (|blk);

    // -----------------------------------------------------------------------
    // Read capture.
    // -----------------------------------------------------------------------
    logic              accept;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic              rd_valid_q;

    assign accept = re_i && !hazard_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= accept;
            if (accept) begin
                rd1_q <= src[0];
                rd2_q <= src[1];
            end
        end
    end

    assign rd1_o      = rd1_q;
    assign rd2_o      = rd2_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        sb;
        logic [3:0]  sba;
        logic [31:0] pc;
        logic        hz;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        vld;
        logic [15:0] bsy;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        re, we3, sb_set;
    logic [3:0]  ra1, ra2, wa3, sb_addr;
    logic [31:0] wd3, pc_in;
    logic [31:0] rd1, rd2;
    logic        rd_valid, hazard;
    logic [15:0] busy;

    // Second instance: narrow data, 8 registers, PC alias at 7.
    logic        s_re, s_we, s_sb;
    logic [3:0]  s_ra1, s_ra2, s_wa, s_sba;
    logic [15:0] s_wd, s_pc;
    logic [15:0] s_rd1, s_rd2;
    logic        s_vld, s_hz;
    logic [7:0]  s_busy;

    int total  = 0;
    int passed = 0;

    regfile_sb dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .re_i       (re),
        .ra1_i      (ra1),
        .ra2_i      (ra2),
        .we3_i      (we3),
        .wa3_i      (wa3),
        .wd3_i      (wd3),
        .pc_in_i    (pc_in),
        .sb_set_i   (sb_set),
        .sb_addr_i  (sb_addr),
        .rd1_o      (rd1),
        .rd2_o      (rd2),
        .rd_valid_o (rd_valid),
        .hazard_o   (hazard),
        .busy_o     (busy)
    );

    regfile_sb #(
        .DATA_W    (16),
        .ADDR_W    (4),
        .NUM_REGS  (8),
        .PC_IDX    (7),
        .PC_OFFSET (8)
    ) dut_s (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .re_i       (s_re),
        .ra1_i      (s_ra1),
        .ra2_i      (s_ra2),
        .we3_i      (s_we),
        .wa3_i      (s_wa),
        .wd3_i      (s_wd),
        .pc_in_i    (s_pc),
        .sb_set_i   (s_sb),
        .sb_addr_i  (s_sba),
        .rd1_o      (s_rd1),
        .rd2_o      (s_rd2),
        .rd_valid_o (s_vld),
        .hazard_o   (s_hz),
        .busy_o     (s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [3:0] wa, input logic [31:0] wd,
        input logic re, input logic [3:0] ra1_v, input logic [3:0] ra2_v,
        input logic sb, input logic [3:0] sba, input logic [31:0] pc,
        input logic hz, input logic [31:0] r1, input logic [31:0] r2,
        input logic vld, input logic [15:0] bsy);
        vec_t v;
        v.we = we;   v.wa = wa;   v.wd = wd;
        v.re = re;   v.ra1 = ra1_v; v.ra2 = ra2_v;
        v.sb = sb;   v.sba = sba; v.pc = pc;
        v.hz = hz;   v.r1 = r1;   v.r2 = r2;
        v.vld = vld; v.bsy = bsy;
        return v;
    endfunction

    // One vector = one clock: drive at negedge, check hazard before the edge,
    // check registered outputs just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        we3 = v.we;  wa3 = v.wa;  wd3 = v.wd;
        re  = v.re;  ra1 = v.ra1; ra2 = v.ra2;
        sb_set = v.sb; sb_addr = v.sba; pc_in = v.pc;
        #1;
        check({tag, " hazard"}, {31'b0, hazard}, {31'b0, v.hz});
        @(posedge clk);
        #1;
        check({tag, " rd1"}, rd1, v.r1);
        check({tag, " rd2"}, rd2, v.r2);
        check({tag, " rd_valid"}, {31'b0, rd_valid}, {31'b0, v.vld});
        check({tag, " busy"}, {16'b0, busy}, {16'b0, v.bsy});
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        re = 0; we3 = 0; sb_set = 0; ra1 = 0; ra2 = 0; wa3 = 0; sb_addr = 0;
        wd3 = 0; pc_in = 0;
        s_re = 0; s_we = 0; s_sb = 0; s_ra1 = 0; s_ra2 = 0; s_wa = 0; s_sba = 0;
        s_wd = 0; s_pc = 0;

        // we  wa  wd            re ra1 ra2 sb sba pc            hz r1            r2            v  busy
        vecs.push_back(mk(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0,            0, 0,            0,            0, 16'h0000));
        vecs.push_back(mk(0, 0, 0,            1, 5, 0, 0, 0, 0,            0, 32'h12345678, 0,            1, 16'h0000));
        vecs.push_back(mk(1, 7, 32'h11111111, 1, 7, 5, 0, 0, 0,            0, 32'h11111111, 32'h12345678, 1, 16'h0000));
        vecs.push_back(mk(1, 7, 32'hA5A5A5A5, 1, 7, 7, 0, 0, 0,            0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 16'h0000));
        vecs.push_back(mk(0, 0, 0,            1, 15, 7, 0, 0, 32'h00000100, 0, 32'h00000108, 32'hA5A5A5A5, 1, 16'h0000));
        vecs.push_back(mk(0, 0, 0,            1, 15, 15, 0, 0, 32'hFFFFFFFC, 0, 32'h00000004, 32'h00000004, 1, 16'h0000));
        vecs.push_back(mk(1, 15, 32'h1,       1, 15, 0, 0, 0, 0,            0, 32'h00000008, 0,            1, 16'h0000));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 1, 2, 0,            0, 32'h00000008, 0,            0, 16'h0004));
        vecs.push_back(mk(0, 0, 0,            1, 0, 2, 0, 0, 0,            1, 32'h00000008, 0,            0, 16'h0004));
        vecs.push_back(mk(1, 2, 32'h55,       1, 5, 2, 0, 0, 0,            0, 32'h12345678, 32'h55,       1, 16'h0000));
        vecs.push_back(mk(1, 4, 32'h44,       0, 0, 0, 1, 4, 0,            0, 32'h12345678, 32'h55,       0, 16'h0010));
        vecs.push_back(mk(0, 0, 0,            1, 4, 4, 0, 0, 0,            1, 32'h12345678, 32'h55,       0, 16'h0010));
        vecs.push_back(mk(1, 4, 32'h99,       1, 6, 4, 1, 6, 0,            0, 0,            32'h99,       1, 16'h0040));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 1, 15, 0,           0, 0,            32'h99,       0, 16'h0040));
        vecs.push_back(mk(1, 6, 32'h66,       1, 6, 6, 0, 0, 0,            0, 32'h66,       32'h66,       1, 16'h0000));
        vecs.push_back(mk(0, 0, 0,            1, 4, 5, 0, 0, 0,            0, 32'h99,       32'h12345678, 1, 16'h0000));

        #12;
        check("reset rd1", rd1, 0);
        check("reset rd2", rd2, 0);
        check("reset rd_valid", {31'b0, rd_valid}, 0);
        check("reset busy", {16'b0, busy}, 0);
        check("reset hazard", {31'b0, hazard}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset in the middle of activity.
        apply(mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 32'h99, 32'h12345678, 0, 16'h0002), "r0");
        apply(mk(0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 16'h0002), "r1");
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset rd1", rd1, 0);
        check("midreset rd2", rd2, 0);
        check("midreset rd_valid", {31'b0, rd_valid}, 0);
        check("midreset busy", {16'b0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000), "r2");

        // Narrow instance: out-of-range index, no aliasing, 16-bit PC wrap.
        @(negedge clk);
        re = 0; we3 = 0; sb_set = 0;
        s_we = 1; s_wa = 3; s_wd = 16'h1234;
        @(negedge clk);
        s_we = 1; s_wa = 9; s_wd = 16'hBEEF; s_sb = 1; s_sba = 9;
        s_re = 1; s_ra1 = 9; s_ra2 = 3;
        #1;
        check("s9 hazard", {31'b0, s_hz}, 0);
        @(posedge clk);
        #1;
        check("s9 rd1", {16'b0, s_rd1}, 0);
        check("s9 rd2", {16'b0, s_rd2}, 32'h1234);
        check("s9 rd_valid", {31'b0, s_vld}, 1);
        check("s9 busy", {24'b0, s_busy}, 0);
        @(negedge clk);
        s_we = 0; s_sb = 0; s_re = 1; s_ra1 = 7; s_ra2 = 1; s_pc = 16'hFFFE;
        #1;
        check("spc hazard", {31'b0, s_hz}, 0);
        @(posedge clk);
        #1;
        check("spc rd1", {16'b0, s_rd1}, 32'h0006);
        check("spc rd2", {16'b0, s_rd2}, 0);
        check("spc rd_valid", {31'b0, s_vld}, 1);
        @(negedge clk);
        s_re = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
